// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with whole-frame debouncing.
// Drives one column low at a time and reports each debounced key press once.
module keypad_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] tecla,
  output logic       valida,
  output logic       presionada
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);
  localparam logic [1:0] K_NONE  = 2'd0;
  localparam logic [1:0] K_ONE   = 2'd1;
  localparam logic [1:0] K_MULTI = 2'd2;

  typedef enum logic {IDLE, HELD} state_t;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] cnt);
    logic [SW-1:0] res;
    if (cnt >= STABLE_MAX) res = STABLE_MAX;
    else                   res = cnt + SW'(1);
    return res;
  endfunction

  logic [3:0]    filas_p0, filas_s;
  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic [1:0]    acc_kind, prev_kind, cand_kind;
  logic [3:0]    acc_code, prev_code, cand_code;
  logic [SW-1:0] stable_cnt, stable_nxt;
  logic [2:0]    zeros;
  logic [1:0]    zrow;
  logic          sample, frame_end;
  logic          valida_d, load_tecla;
  state_t        state_q, state_d;

  assign columnas   = ~(4'b0001 << col);
  assign presionada = (state_q == HELD);
  assign sample     = (dwell == DWELL_LAST);
  assign frame_end  = sample && (col == 2'd3);

  // Fold this column's row sample into the running frame candidate.
  always_comb begin
    zeros     = 3'd0;
    zrow      = 2'd0;
    cand_kind = acc_kind;
    cand_code = acc_code;
    for (int r = 0; r < 4; r++) begin
      if (!filas_s[r]) begin
        zeros = zeros + 3'd1;
        zrow  = 2'(r);
      end
    end
    if (zeros != 3'd0) begin
      if (acc_kind == K_NONE && zeros == 3'd1) begin
        cand_kind = K_ONE;
        cand_code = {zrow, col};
      end else begin
        cand_kind = K_MULTI;
        cand_code = 4'd0;
      end
    end
    if ({cand_kind, cand_code} == {prev_kind, prev_code}) stable_nxt = sat_inc(stable_cnt);
    else                                                  stable_nxt = SW'(1);
  end

  always_comb begin
    state_d    = state_q;
    valida_d   = 1'b0;
    load_tecla = 1'b0;
    if (frame_end && stable_nxt == STABLE_MAX) begin
      case (state_q)
        IDLE: if (cand_kind == K_ONE) begin
          state_d    = HELD;
          valida_d   = 1'b1;
          load_tecla = 1'b1;
        end
        HELD: if (cand_kind == K_NONE) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Synchronizer, scan counters, frame accumulator and report registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filas_p0   <= 4'hF;
      filas_s    <= 4'hF;
      dwell      <= '0;
      col        <= 2'd0;
      acc_kind   <= K_NONE;
      acc_code   <= 4'd0;
      prev_kind  <= K_NONE;
      prev_code  <= 4'd0;
      stable_cnt <= '0;
      tecla      <= 4'd0;
      valida     <= 1'b0;
    end else begin
      filas_p0 <= filas;
      filas_s  <= filas_p0;
      valida   <= valida_d;
      if (load_tecla) tecla <= cand_code;
      if (sample) begin
        dwell <= '0;
        col   <= col + 2'd1;
        if (frame_end) begin
          acc_kind   <= K_NONE;
          acc_code   <= 4'd0;
          prev_kind  <= cand_kind;
          prev_code  <= cand_code;
          stable_cnt <= stable_nxt;
        end else begin
          acc_kind <= cand_kind;
          acc_code <= cand_code;
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, scoreboard of expected key codes.
module tb_keypad_scan;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME    = 4 * SCAN_DIV;
  localparam int BUDGET   = (DEBOUNCE + 1) * FRAME + 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  filas;
  logic [3:0]  columnas;
  logic [3:0]  tecla;
  logic        valida;
  logic        presionada;
  logic [15:0] keys = 16'h0;
  logic [3:0]  exp_q[$];
  logic        valida_prev = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst_n(rst_n), .filas(filas), .columnas(columnas),
    .tecla(tecla), .valida(valida), .presionada(presionada)
  );

  always #5 clk = ~clk;

  always_comb begin
    filas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !columnas[c]) filas[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (valida === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_valida", 32'(valida), 32'd0);
      else chk("tecla", 32'(tecla), 32'(exp_q.pop_front()));
    end
    if (valida === 1'b1 && valida_prev) chk("valida_width", 32'(valida_prev), 32'd0);
    valida_prev = (valida === 1'b1);
  end

  task automatic wait_pres(input string tag, input logic lvl, input int budget);
    int n = 0;
    @(negedge clk);
    while (presionada !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(presionada), 32'(lvl));
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic reset_now();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_columnas", 32'(columnas), 32'hE);
    chk("rst_tecla", 32'(tecla), 32'd0);
    chk("rst_valida", 32'(valida), 32'd0);
    chk("rst_presionada", 32'(presionada), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset, then mid-frame reset and column stepping.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    reset_now();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= FRAME; k++) begin
      #1;
      chk("col_step", 32'(columnas), 32'(~(4'b0001 << ((k / SCAN_DIV) % 4)) & 4'hF));
      @(negedge clk);
    end

    // Single press of key (2,1).
    frames(2);
    exp_q.push_back(4'd9);
    keys = 16'h0200;
    wait_pres("press9", 1'b1, BUDGET);
    frames(9);
    chk("hold9_pres", 32'(presionada), 32'd1);
    keys = 16'h0;
    wait_pres("release9", 1'b0, BUDGET);
    chk("sb_empty9", 32'(exp_q.size()), 32'd0);
    chk("tecla_hold", 32'(tecla), 32'd9);

    // Repeat key 5 with long then short release.
    frames(2);
    exp_q.push_back(4'd5);
    keys = 16'h0020;
    wait_pres("press5a", 1'b1, BUDGET);
    frames(4);
    keys = 16'h0;
    frames(3);
    exp_q.push_back(4'd5);
    keys = 16'h0020;
    frames(4);
    chk("sb_empty5", 32'(exp_q.size()), 32'd0);
    chk("pres5b", 32'(presionada), 32'd1);
    keys = 16'h0;
    frames(1);
    keys = 16'h0020;
    frames(4);
    chk("short_rel_pres", 32'(presionada), 32'd1);
    keys = 16'h0;
    wait_pres("release5", 1'b0, BUDGET);

    // Two keys together, then drop (3,3).
    frames(2);
    keys = 16'h8001;
    frames(6);
    chk("multi_pres", 32'(presionada), 32'd0);
    chk("multi_tecla", 32'(tecla), 32'd5);
    exp_q.push_back(4'd0);
    keys = 16'h0001;
    wait_pres("press0", 1'b1, BUDGET);
    keys = 16'h0;
    wait_pres("release0", 1'b0, BUDGET);
    chk("sb_empty0", 32'(exp_q.size()), 32'd0);

    // Bounce on key 14, then stable.
    frames(2);
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? 16'h4000 : 16'h0000;
      frames(1);
    end
    chk("bounce_pres", 32'(presionada), 32'd0);
    exp_q.push_back(4'd14);
    keys = 16'h4000;
    wait_pres("press14", 1'b1, BUDGET);
    keys = 16'h0;
    wait_pres("release14", 1'b0, BUDGET);

    // Reset while held on key 7.
    frames(2);
    exp_q.push_back(4'd7);
    keys = 16'h0080;
    wait_pres("press7", 1'b1, BUDGET);
    frames(2);
    reset_now();
    repeat (2) @(negedge clk);
    exp_q.push_back(4'd7);
    rst_n = 1'b1;
    wait_pres("press7_again", 1'b1, BUDGET);
    frames(1);
    chk("tecla7", 32'(tecla), 32'd7);
    keys = 16'h0;
    wait_pres("release7", 1'b0, BUDGET);
    chk("sb_empty_end", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
